// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
//   Turns the PS/2 scan-byte stream into whole key events. The block decodes
//   the E0 (extended) and F0 (break) prefixes, drops controller status bytes,
//   and queues each event in a first-word-fall-through FIFO that the consumer
//   reads with a valid/ready handshake. It also keeps an up/down cursor that
//   the W (1D) and S (1B) keys move. Held-key repeats do not move the cursor.
// Ports
//   CLOCK_50   system clock, all logic on posedge
//   rst        asynchronous active-high reset
//   byte_en    1-cycle strobe, byte_data holds a new scan byte
//   byte_data  scan byte from the PS/2 receiver
//   evt_valid  FIFO head holds an event
//   evt_ready  consumer takes the head event this cycle
//   evt_code   head event scan code
//   evt_ext    head event was E0-prefixed
//   evt_break  head event is a key release
//   fifo_count entries queued
//   cursor     cursor counter
//   overflow   sticky, an event was dropped on a full FIFO
//   proto_err  1-cycle pulse on an illegal prefix order
module ps2_key_event_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 18,
  parameter int unsigned CNT_INIT   = 1
) (
  input  logic                          CLOCK_50,
  input  logic                          rst,
  input  logic                          byte_en,
  input  logic [7:0]                    byte_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]              cursor,
  output logic                          overflow,
  output logic                          proto_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e state_q, state_d;
  logic   emit, emit_ext, emit_brk, perr;
  logic   is_status;

  assign is_status = byte_data inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  // Decode of the current byte against the prefix seen so far.
  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    perr     = 1'b0;
    if (byte_en) begin
      unique case (state_q)
        StIdle: begin
          if (byte_data == 8'hE0)      state_d = StExt;
          else if (byte_data == 8'hF0) state_d = StBrk;
          else if (!is_status)         emit = 1'b1;
        end
        StExt: begin
          if (byte_data == 8'hF0) begin
            state_d = StExtBrk;
          end else if (byte_data == 8'hE0) begin
            state_d = StIdle;
            perr    = 1'b1;
          end else begin
            state_d  = StIdle;
            emit     = 1'b1;
            emit_ext = 1'b1;
          end
        end
        StBrk, StExtBrk: begin
          state_d = StIdle;
          if (byte_data == 8'hE0 || byte_data == 8'hF0) begin
            perr = 1'b1;
          end else begin
            emit     = 1'b1;
            emit_ext = (state_q == StExtBrk);
            emit_brk = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      proto_err <= perr;
    end
  end

  // Event FIFO: entry is {code, ext, brk}.
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, pop, push;

  assign full = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop  = (count_q != '0) && evt_ready;
  // A pop frees the slot that a push into a full FIFO needs.
  assign push = emit && (!full || pop);

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {byte_data, emit_ext, emit_brk};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
      if (emit && !push) overflow <= 1'b1;
    end
  end

  assign evt_valid  = (count_q != '0);
  assign evt_code   = mem_q[rd_ptr_q][9:2];
  assign evt_ext    = mem_q[rd_ptr_q][1];
  assign evt_break  = mem_q[rd_ptr_q][0];
  assign fifo_count = count_q;

  // Cursor with repeat filter. It follows the decoded events whether or not
  // the FIFO has room for them.
  logic held_up, held_dn;

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      cursor  <= CNT_W'(CNT_INIT);
      held_up <= 1'b0;
      held_dn <= 1'b0;
    end else if (emit && !emit_ext) begin
      if (byte_data == 8'h1D) begin
        if (emit_brk) begin
          held_up <= 1'b0;
        end else if (!held_up) begin
          cursor  <= cursor + CNT_W'(1);
          held_up <= 1'b1;
        end
      end else if (byte_data == 8'h1B) begin
        if (emit_brk) begin
          held_dn <= 1'b0;
        end else if (!held_dn) begin
          cursor  <= cursor - CNT_W'(1);
          held_dn <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
module tb_ps2_key_event_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        rst = 1'b0;
  logic        byte_en = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        evt_ready = 1'b0;
  logic        evt_valid, evt_ext, evt_break, overflow, proto_err;
  logic [7:0]  evt_code;
  logic [2:0]  fifo_count;
  logic [17:0] cursor;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_key_event_ctrl #(.FIFO_DEPTH(4), .CNT_W(18), .CNT_INIT(1)) dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .byte_en   (byte_en),
    .byte_data (byte_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .fifo_count(fifo_count),
    .cursor    (cursor),
    .overflow  (overflow),
    .proto_err (proto_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Drive inputs after a falling edge, let one rising edge pass, return at the
  // next falling edge so outputs can be sampled.
  task automatic drive(input logic be, input logic [7:0] d, input logic rdy);
    byte_en   = be;
    byte_data = d;
    evt_ready = rdy;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic reset_dut();
    @(negedge CLOCK_50);
    byte_en = 1'b0; byte_data = 8'h00; evt_ready = 1'b0;
    rst = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLOCK_50);
    rst = 1'b1;
    #3;
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_checks++; if (cursor !== 18'd1) begin n_fail++; $display("FAIL reset_cursor: got %0d want 1", cursor); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", proto_err); end
    @(negedge CLOCK_50);
    rst = 1'b0;
  endtask

  task automatic test_make();
    reset_dut();
    drive(1'b1, 8'h1D, 1'b0);
    n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL make_valid: got %b want 1", evt_valid); end
    n_checks++; if ({evt_code, evt_ext, evt_break} !== {8'h1D, 2'b00}) begin
      n_fail++; $display("FAIL make_head: got %h/%b/%b want 1d/0/0", evt_code, evt_ext, evt_break); end
    n_checks++; if (cursor !== 18'd2) begin n_fail++; $display("FAIL make_cursor: got %0d want 2", cursor); end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_repeat_overflow();
    reset_dut();
    drive(1'b1, 8'h1D, 1'b0);
    drive(1'b1, 8'h1D, 1'b0);
    drive(1'b1, 8'h1D, 1'b0);
    n_checks++; if (cursor !== 18'd2) begin n_fail++; $display("FAIL repeat_cursor: got %0d want 2", cursor); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL repeat_ovf_early: got %b want 0", overflow); end
    drive(1'b1, 8'hF0, 1'b0);
    drive(1'b1, 8'h1D, 1'b0);
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL repeat_count4: got %0d want 4", fifo_count); end
    drive(1'b1, 8'h1D, 1'b0);
    n_checks++; if (cursor !== 18'd3) begin n_fail++; $display("FAIL rearm_cursor: got %0d want 3", cursor); end
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL sat_count: got %0d want 4", fifo_count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b want 1", overflow); end
    drive(1'b0, 8'h00, 1'b0);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_ext_break();
    reset_dut();
    drive(1'b1, 8'hE0, 1'b1);
    drive(1'b1, 8'hF0, 1'b1);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL extbrk_prefix_valid: got %b want 0", evt_valid); end
    drive(1'b1, 8'h75, 1'b1);
    n_checks++; if ({evt_valid, evt_code, evt_ext, evt_break} !== {1'b1, 8'h75, 2'b11}) begin
      n_fail++; $display("FAIL extbrk_head: got %b/%h/%b/%b want 1/75/1/1", evt_valid, evt_code, evt_ext, evt_break); end
    n_checks++; if (cursor !== 18'd1) begin n_fail++; $display("FAIL extbrk_cursor: got %0d want 1", cursor); end
    drive(1'b0, 8'h00, 1'b1);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL extbrk_pop: got %b want 0", evt_valid); end
    // Extended W never moves the cursor.
    drive(1'b1, 8'hE0, 1'b0);
    drive(1'b1, 8'h1D, 1'b0);
    n_checks++; if ({cursor, evt_ext} !== {18'd1, 1'b1}) begin
      n_fail++; $display("FAIL ext_w: got %0d/%b want 1/1", cursor, evt_ext); end
  endtask

  task automatic test_proto_err();
    reset_dut();
    drive(1'b1, 8'hF0, 1'b0);
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL perr_early: got %b want 0", proto_err); end
    drive(1'b1, 8'hE0, 1'b0);
    n_checks++; if ({proto_err, fifo_count} !== {1'b1, 3'd0}) begin
      n_fail++; $display("FAIL perr_pulse: got %b/%0d want 1/0", proto_err, fifo_count); end
    drive(1'b1, 8'h1B, 1'b0);
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL perr_one_cycle: got %b want 0", proto_err); end
    n_checks++; if ({cursor, evt_code, evt_break} !== {18'd0, 8'h1B, 1'b0}) begin
      n_fail++; $display("FAIL perr_then_s: got %0d/%h/%b want 0/1b/0", cursor, evt_code, evt_break); end
    drive(1'b1, 8'hF0, 1'b0);
    drive(1'b1, 8'h1B, 1'b0);
    drive(1'b1, 8'h1B, 1'b0);
    n_checks++; if (cursor !== 18'h3FFFF) begin n_fail++; $display("FAIL cursor_wrap: got %h want 3ffff", cursor); end
    n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL perr_count: got %0d want 3", fifo_count); end
    // E0 E0 is illegal too; status byte after a prefix is a code.
    drive(1'b1, 8'hE0, 1'b0);
    drive(1'b1, 8'hE0, 1'b0);
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_e0e0: got %b want 1", proto_err); end
    drive(1'b1, 8'hF0, 1'b0);
    drive(1'b1, 8'hAA, 1'b0);
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL brk_status_code: got %0d want 4", fifo_count); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_codes [4];
    exp_codes[0] = 8'h12; exp_codes[1] = 8'h13; exp_codes[2] = 8'h14; exp_codes[3] = 8'h2A;
    reset_dut();
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h12, 1'b0);
    drive(1'b1, 8'h13, 1'b0);
    drive(1'b1, 8'h14, 1'b0);
    drive(1'b1, 8'h2A, 1'b1);
    n_checks++; if ({fifo_count, overflow} !== {3'd4, 1'b0}) begin
      n_fail++; $display("FAIL full_pushpop: got %0d/%b want 4/0", fifo_count, overflow); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (evt_code !== exp_codes[i]) begin
        n_fail++; $display("FAIL drain_%0d: got %h want %h", i, evt_code, exp_codes[i]); end
      drive(1'b0, 8'h00, 1'b1);
    end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", evt_valid); end
    drive(1'b0, 8'h00, 1'b1);
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL pop_empty: got %0d want 0", fifo_count); end
  endtask

  task automatic test_reset_midstream();
    reset_dut();
    drive(1'b1, 8'hE0, 1'b0);
    reset_dut();
    drive(1'b1, 8'h1D, 1'b0);
    n_checks++; if ({evt_valid, evt_ext, cursor} !== {1'b1, 1'b0, 18'd2}) begin
      n_fail++; $display("FAIL midrst: got %b/%b/%0d want 1/0/2", evt_valid, evt_ext, cursor); end
    drive(1'b1, 8'hAA, 1'b0);
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL status_drop: got %0d want 1", fifo_count); end
  endtask

  // Randomised traffic against a prefix-flag model with a queue for the FIFO.
  task automatic test_random();
    logic [9:0] mq[$];
    logic [7:0] pool [10];
    bit  in_prefix, p_ext, p_brk, held_up, held_dn, m_ovf, m_perr;
    int  m_cur;
    pool[0] = 8'h1D; pool[1] = 8'h1B; pool[2] = 8'hE0; pool[3] = 8'hF0; pool[4] = 8'hAA;
    pool[5] = 8'hFA; pool[6] = 8'h00; pool[7] = 8'hFF; pool[8] = 8'h75; pool[9] = 8'h2A;
    reset_dut();
    in_prefix = 0; p_ext = 0; p_brk = 0; held_up = 0; held_dn = 0; m_ovf = 0; m_cur = 1;
    for (int c = 0; c < 3000; c++) begin
      logic       be, rdy, em, eext, ebrk, do_pop;
      logic [7:0] d;
      be  = ($urandom_range(0, 3) != 0);
      d   = ($urandom_range(0, 5) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
      rdy = ($urandom_range(0, 2) == 0);
      byte_en = be; byte_data = d; evt_ready = rdy;
      @(posedge CLOCK_50);
      do_pop = (mq.size() > 0) && rdy;
      m_perr = 0; em = 0; eext = 0; ebrk = 0;
      if (be) begin
        if (!in_prefix) begin
          if (d == 8'hE0) begin in_prefix = 1; p_ext = 1; p_brk = 0; end
          else if (d == 8'hF0) begin in_prefix = 1; p_ext = 0; p_brk = 1; end
          else if (!(d inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) em = 1;
        end else if (d == 8'hE0 || (d == 8'hF0 && p_brk)) begin
          m_perr = 1; in_prefix = 0;
        end else if (d == 8'hF0) begin
          p_brk = 1;
        end else begin
          em = 1; eext = p_ext; ebrk = p_brk; in_prefix = 0;
        end
      end
      if (em) begin
        if (mq.size() < 4 || do_pop) mq.push_back({d, eext, ebrk});
        else m_ovf = 1;
        if (!eext && d == 8'h1D) begin
          if (ebrk) held_up = 0;
          else if (!held_up) begin m_cur = (m_cur + 1) % 262144; held_up = 1; end
        end
        if (!eext && d == 8'h1B) begin
          if (ebrk) held_dn = 0;
          else if (!held_dn) begin m_cur = (m_cur + 262143) % 262144; held_dn = 1; end
        end
      end
      if (do_pop) void'(mq.pop_front());
      @(negedge CLOCK_50);
      n_checks++; if (fifo_count !== 3'(mq.size())) begin
        n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, fifo_count, mq.size()); end
      n_checks++; if (evt_valid !== (mq.size() > 0)) begin
        n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, evt_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        n_checks++; if ({evt_code, evt_ext, evt_break} !== mq[0]) begin
          n_fail++; $display("FAIL rnd_head c%0d: got %h want %h", c, {evt_code, evt_ext, evt_break}, mq[0]); end
      end
      n_checks++; if (cursor !== 18'(m_cur)) begin
        n_fail++; $display("FAIL rnd_cursor c%0d: got %0d want %0d", c, cursor, m_cur); end
      n_checks++; if ({overflow, proto_err} !== {m_ovf, m_perr}) begin
        n_fail++; $display("FAIL rnd_flags c%0d: got %b%b want %b%b", c, overflow, proto_err, m_ovf, m_perr); end
    end
    byte_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_make();
    test_repeat_overflow();
    test_ext_break();
    test_proto_err();
    test_full_push_pop();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
